// File: rtl/mostrar_nota.sv
// mostrar_nota
// Turns a validated key press from a 13-key octave keyboard into a multi-digit
// glyph display. The display shows the octave number, the note letter and a
// sharp sign. It holds the note either for a fixed number of clocks or until
// the next key press.
//
// Ports
//   clk          : single clock, all state updates on its rising edge
//   reset_n      : asynchronous, active-low reset
//   tecla        : key index, 1..13 valid (13 = C of the next octave)
//   tecla_valida : one-cycle strobe qualifying tecla
//   octava       : current octave selection
//   modo         : 0 = timed hold, 1 = hold until the next key
//   resultado    : packed glyph codes, digit DIGITS-1 in the MSBs
//   activo       : high while a note is displayed
//   nota         : latched key index, 0 when idle
//
// Glyph codes: 0..9 are digits, A..G are 10..16, '#' is 17 and blank is 31.
module mostrar_nota #(
  parameter int DIGITS      = 8,
  parameter int CODE_W      = 5,
  parameter int OCT_W       = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [3:0]                 tecla,
  input  logic                       tecla_valida,
  input  logic [OCT_W-1:0]           octava,
  input  logic                       modo,
  output logic [DIGITS*CODE_W-1:0]   resultado,
  output logic                       activo,
  output logic [3:0]                 nota
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [OCT_W-1:0]  MAX_OCT   = {OCT_W{1'b1}};
  localparam logic [CODE_W-1:0] BLANK     = CODE_W'(31);
  localparam logic [CODE_W-1:0] SHARP     = CODE_W'(17);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [3:0]                  r_nota;
  logic [OCT_W-1:0]            r_oct;
  logic [DIGITS*CODE_W-1:0]    r_resultado;
  logic                        r_activo;

  state_t                      w_nextState;
  logic [CNT_W-1:0]            w_nextCnt;
  logic [3:0]                  w_nextNota;
  logic [OCT_W-1:0]            w_nextOct;
  logic [DIGITS*CODE_W-1:0]    w_nextRes;
  logic                        w_accept;

  // Letter glyph for each key; keys 1 and 13 are both C, 13 being one octave up.
  function automatic logic [CODE_W-1:0] letterOf(input logic [3:0] k);
    logic [CODE_W-1:0] code;
    code = BLANK;
    case (k)
      4'd1, 4'd2, 4'd13: code = CODE_W'(12);
      4'd3, 4'd4:        code = CODE_W'(13);
      4'd5:              code = CODE_W'(14);
      4'd6, 4'd7:        code = CODE_W'(15);
      4'd8, 4'd9:        code = CODE_W'(16);
      4'd10, 4'd11:      code = CODE_W'(10);
      4'd12:             code = CODE_W'(11);
      default:           code = BLANK;
    endcase
    return code;
  endfunction

  // The black keys are the sharps in the key layout.
  function automatic logic isSharp(input logic [3:0] k);
    return (k == 4'd2) || (k == 4'd4) || (k == 4'd7) ||
           (k == 4'd9) || (k == 4'd11);
  endfunction

  assign w_accept = tecla_valida && (tecla >= 4'd1) && (tecla <= 4'd13);

  // Next-state logic. An accepted key wins over everything, including a
  // timeout in the same cycle. Without one, SHOW counts down only in timed
  // mode and keeps the counter frozen in hold mode, so switching back to
  // timed mode resumes from where it stopped.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextNota  = r_nota;
    w_nextOct   = r_oct;
    if (w_accept) begin
      w_nextState = SHOW;
      w_nextCnt   = HOLD_LOAD;
      w_nextNota  = tecla;
      if (tecla == 4'd13) begin
        w_nextOct = (octava == MAX_OCT) ? MAX_OCT : octava + OCT_W'(1);
      end else begin
        w_nextOct = octava;
      end
    end else if ((r_state == SHOW) && !modo) begin
      if (r_cnt == '0) begin
        w_nextState = IDLE;
        w_nextNota  = 4'd0;
      end else begin
        w_nextCnt = r_cnt - CNT_W'(1);
      end
    end
  end

  // Display image for the upcoming cycle. It is built from the next state so
  // that the registered outputs line up with the registered state.
  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      w_nextRes[d*CODE_W +: CODE_W] = BLANK;
    end
    if (w_nextState == SHOW) begin
      w_nextRes[(DIGITS-1)*CODE_W +: CODE_W] = CODE_W'(w_nextOct);
      w_nextRes[CODE_W +: CODE_W]            = letterOf(w_nextNota);
      w_nextRes[0 +: CODE_W]                 = isSharp(w_nextNota) ? SHARP : BLANK;
    end else begin
      w_nextRes[(DIGITS-1)*CODE_W +: CODE_W] = CODE_W'(octava);
    end
  end

  // State and output registers. Reset blanks every digit, including the
  // octave digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nota      <= 4'd0;
      r_oct       <= '0;
      r_resultado <= {DIGITS{BLANK}};
      r_activo    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_nota      <= w_nextNota;
      r_oct       <= w_nextOct;
      r_resultado <= w_nextRes;
      r_activo    <= (w_nextState == SHOW);
    end
  end

  assign resultado = r_resultado;
  assign activo    = r_activo;
  assign nota      = r_nota;

endmodule

// File: doc/mostrar_nota.md
MOSTRAR_NOTA -- requirements
Module: mostrar_nota

Interface
REQ-001 Parameter DIGITS, default 8, number of display digits (SHALL be >= 3).
REQ-002 Parameter CODE_W, default 5, bits per digit code.
REQ-003 Parameter OCT_W, default 3, octave width (2^OCT_W-1 SHALL be <= 9).
REQ-004 Parameter HOLD_CYCLES, default 50_000_000, display hold time in clocks (>= 1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 tecla  input  4  key index; 1..13 valid, 0 and 14..15 invalid.
REQ-008 tecla_valida  input  1  one-cycle strobe qualifying tecla.
REQ-009 octava  input  OCT_W  current octave selection.
REQ-010 modo  input  1  0 = timed hold, 1 = hold until next key.
REQ-011 resultado  output  DIGITS*CODE_W  packed digit codes; digit DIGITS-1 in MSBs.
REQ-012 activo  output  1  high while a note is displayed.
REQ-013 nota  output  4  latched key index, 0 when idle.

Function
REQ-014 Glyph codes: 0..9 digits; A=10, B=11, C=12, D=13, E=14, F=15, G=16; '#'=17; blank=31 (CODE_W-bit, zero-extended).
REQ-015 Key map: 1 C, 2 C#, 3 D, 4 D#, 5 E, 6 F, 7 F#, 8 G, 9 G#, 10 A, 11 A#, 12 B, 13 C of next octave.
REQ-016 FSM states: IDLE, SHOW; reset state IDLE.
REQ-017 Accepted event: tecla_valida=1 and tecla in 1..13; other strobes SHALL be ignored with no state change.
REQ-018 On an accepted event in any state: latch key to nota, latch octave (octava, or octava+1 saturating at 2^OCT_W-1 for key 13), load hold counter with HOLD_CYCLES-1, go to SHOW.
REQ-019 In SHOW with modo=0: counter decrements each cycle; when counter is 0 and no accepted event, go to IDLE; SHOW lasts exactly HOLD_CYCLES cycles after the event cycle.
REQ-020 In SHOW with modo=1: counter frozen; exit only via reset; new events replace the displayed note.
REQ-021 modo changing 1->0 during SHOW: countdown resumes from frozen value.
REQ-022 Accepted event in same cycle as timeout: event wins; stays SHOW with reloaded counter.
REQ-023 SHOW display: digit DIGITS-1 = latched octave; digit 1 = note letter; digit 0 = '#' if sharp else blank; all others blank.
REQ-024 IDLE display: digit DIGITS-1 = live octava; all others blank.
REQ-025 resultado, activo, nota SHALL be registered; first cycle showing a note is the cycle after the accepting edge (1-cycle latency).
REQ-026 activo = 1 exactly when registered state is SHOW; nota = 0 in IDLE.
REQ-027 Octave changes on octava during SHOW SHALL NOT alter the displayed note octave.

Reset
REQ-028 reset_n low: state IDLE, counter 0, nota 0, activo 0, resultado all digits blank (31) including octave digit, immediately and asynchronously.
REQ-029 Reset assertion mid-SHOW SHALL abort the note; after release, IDLE display per REQ-024 from the first clock edge.
REQ-030 Strobes while reset_n low SHALL be ignored.

Verification (DIGITS=8, CODE_W=5, OCT_W=3, HOLD_CYCLES=4)
REQ-031 Reset then octava=3, no strobes -> resultado digits {3,31,31,31,31,31,31,31}, activo=0, nota=0.
REQ-032 modo=0, octava=4, strobe tecla=2 -> next cycle digits {4,31,31,31,31,31,12,17}, activo=1, nota=2 for 4 cycles, then IDLE {4,31,...,31}.
REQ-033 octava=7, strobe tecla=13 -> octave digit 7 (saturated), letter 12, digit 0 = 31.
REQ-034 modo=0, strobe tecla=5, strobe tecla=10 on the timeout cycle -> shows A (10) for 4 further cycles, no IDLE cycle between.
REQ-035 Strobe tecla=0 and tecla=14 in IDLE -> no change; modo=1, strobe tecla=12 -> B shown indefinitely (>= 20 cycles) until reset_n pulse -> all-blank, activo=0.
